ws_sta_array: RTL and testbench
===============================

Name: ws_sta_array

Overview:
- Parametrised weight-stationary systolic array of ROWS x COLS multiply-accumulate PEs; successor to the fixed 32x32 ws_sta_32x32x1x1x1.
- Adds several features the fixed array lacks:
  - valid/ready handshakes on both operand streams;
  - double-buffered (shadow/active) weights with a commit that waits for the pipeline to drain;
  - internal input skew and output deskew, so callers present and receive whole aligned vectors;
  - a signed/unsigned arithmetic parameter.
- Sits between the operand fetch logic and the result writeback buffer of the accelerator datapath.

Parameters:
- ROWS, 32, PE rows; length of an A vector; depth of the weight load.
- COLS, 32, PE columns; length of B and C vectors.
- DATA_W, 8, width of A and B elements.
- ACC_W, 2*DATA_W+$clog2(ROWS), width of C elements (21 at defaults).
- SIGNED, 0, 1 = two's-complement A/B/C; 0 = unsigned.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_b_valid  in  1  weight vector present.
- io_b_data  in  COLS*DATA_W  weight vector; element c at bits [c*DATA_W +: DATA_W].
- io_b_ready  out  1  shadow weights accept a vector.
- io_b_commit  in  1  single-cycle request to copy shadow weights into active weights.
- io_b_count  out  $clog2(ROWS+1)  vectors loaded since last commit; saturates at ROWS.
- io_a_valid  in  1  activation vector present.
- io_a_data  in  ROWS*DATA_W  activation vector; element r at bits [r*DATA_W +: DATA_W].
- io_a_ready  out  1  array accepts an activation vector.
- io_c_valid  out  1  result vector valid; one-cycle pulse per accepted A vector.
- io_c_data  out  COLS*ACC_W  result vector; element c at bits [c*ACC_W +: ACC_W].
- io_busy  out  1  any accepted A vector still in the skew, array or deskew pipeline.

Behaviour:
- Reset (reset low, asynchronous):
  - shadow weights, active weights, all pipeline registers, io_b_count and the pending-commit flag clear to 0.
  - io_c_valid=0, io_c_data=0, io_busy=0, io_a_ready=1, io_b_ready=1.
  - Reset asserted mid-operation discards all in-flight vectors; no io_c_valid follows.
- Weight load (transfer = io_b_valid & io_b_ready):
  - Shadow row r takes shadow row r-1; shadow row 0 takes io_b_data.
  - After ROWS transfers, the first vector loaded sits in row ROWS-1.
  - io_b_count increments, saturating at ROWS.
  - Further loads keep shifting; the oldest row is dropped off the bottom.
- Commit:
  - io_b_commit with io_busy=0: active weights take the shadow contents at that edge, including a same-cycle load. io_b_count clears to 0; shadow is unchanged.
  - io_b_commit with io_busy=1: the pending flag sets. While pending, io_a_ready=0 and io_b_ready=0.
  - The pending commit executes at the first edge where io_busy=0; pending then clears and io_a_ready/io_b_ready return to 1 the next cycle.
  - A commit arriving while one is already pending is absorbed (single pending slot).
  - A commit with io_b_count<ROWS is legal; unloaded rows keep their old shadow values.
- Compute (transfer = io_a_valid & io_a_ready, io_a_ready = !pending):
  - Element r is delayed r cycles before entering row r.
  - PE(r,c) registers A rightward and registers psum downward: psum_out = psum_in + a*w_active[r][c].
  - Row 0 psum_in = 0.
  - Column c output is delayed COLS-1-c cycles so all columns align.
- Latency: io_c_valid asserts exactly ROWS+COLS cycles after the accepting edge, with C[c] = sum over r of A[r]*W[r][c].
- Throughput: one vector per cycle, back-to-back; there is no output backpressure.
- Same-edge A transfer and idle commit: the accepted vector uses the newly committed weights.
- Arithmetic:
  - Products are full precision, extended to ACC_W (sign-extended if SIGNED, zero-extended otherwise).
  - Sums wrap modulo 2^ACC_W; at the default ACC_W the worst case cannot overflow.
- Output timing:
  - io_busy is high from the edge after an accept until the edge at which the last io_c_valid pulse is emitted.
  - io_c_data holds its last value while io_c_valid=0.

Test Plan:
- The bench uses ROWS=COLS=4, DATA_W=8, ACC_W=18, with active-low reset.
- 1. Load rows 3..0 as the identity matrix, commit, then send A=[1,2,3,4] -> io_c_valid exactly 8 cycles later, C=[1,2,3,4], io_b_count 4 before commit and 0 after.
- 2. Unsigned, all weights 255, commit, A=[255,255,255,255] -> every C element = 260100.
- 3. SIGNED=1, identity weights scaled by -1 (0xFF), A=[1,-2,3,-4] -> C=[-1,2,-3,4] as 18-bit two's complement (0x3FFFF, 0x00002, ...).
- 4. Stream 4 A vectors on consecutive cycles with identity weights -> 4 consecutive io_c_valid cycles, vectors in order; io_busy falls with the last pulse.
- 5. Assert io_b_commit 2 cycles after an accept with new weights 2*I -> io_a_ready=0 until drain. The in-flight result uses I; a vector sent after io_a_ready returns yields 2*A.
- 6. Pull reset low 3 cycles after an accept -> outputs go to 0 immediately and no io_c_valid pulse occurs after release.

Source files
------------

// File: rtl/ws_sta_array_if.sv
// Operand and result bundle for ws_sta_array: B weight stream with commit, A activation
// stream, C result stream and pipeline status.
interface ws_sta_array_if #(
  parameter int ROWS   = 32,
  parameter int COLS   = 32,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W + $clog2(ROWS)
);
  localparam int CNT_W = $clog2(ROWS + 1);

  logic                     io_b_valid;
  logic [COLS*DATA_W-1:0]   io_b_data;
  logic                     io_b_ready;
  logic                     io_b_commit;
  logic [CNT_W-1:0]         io_b_count;
  logic                     io_a_valid;
  logic [ROWS*DATA_W-1:0]   io_a_data;
  logic                     io_a_ready;
  logic                     io_c_valid;
  logic [COLS*ACC_W-1:0]    io_c_data;
  logic                     io_busy;

  modport master (
    output io_b_valid, io_b_data, io_b_commit, io_a_valid, io_a_data,
    input  io_b_ready, io_b_count, io_a_ready, io_c_valid, io_c_data, io_busy
  );

  modport slave (
    input  io_b_valid, io_b_data, io_b_commit, io_a_valid, io_a_data,
    output io_b_ready, io_b_count, io_a_ready, io_c_valid, io_c_data, io_busy
  );
endinterface

// File: rtl/ws_sta_array.sv
// Weight-stationary ROWS x COLS MAC array with shadow/active weights; C follows an accepted A by
// ROWS+COLS cycles. A and B stall only while a commit waits for drain; no C backpressure.
module ws_sta_array #(
  parameter int ROWS   = 32,
  parameter int COLS   = 32,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W + $clog2(ROWS),
  parameter int SIGNED = 0
) (
  input logic         clock,
  input logic         reset,
  ws_sta_array_if.slave io
);
  localparam int L     = ROWS + COLS;
  localparam int CNT_W = $clog2(ROWS + 1);
  localparam int PW    = 2 * DATA_W;

  logic [DATA_W-1:0] wsh_q  [ROWS][COLS];
  logic [DATA_W-1:0] wsh_d  [ROWS][COLS];
  logic [DATA_W-1:0] wact_q [ROWS][COLS];
  logic [DATA_W-1:0] wact_d [ROWS][COLS];
  logic [DATA_W-1:0] ah_q   [ROWS][COLS];
  logic [DATA_W-1:0] ah_d   [ROWS][COLS];
  logic [ACC_W-1:0]  ps_q   [ROWS][COLS];
  logic [ACC_W-1:0]  ps_d   [ROWS][COLS];

  logic [ROWS-1:0][DATA_W-1:0] row_a;
  logic [COLS-1:0][ACC_W-1:0]  col_c;

  logic [L-1:0]           vld_q, vld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   c_vld_q, c_vld_d;
  logic [COLS*ACC_W-1:0]  c_dat_q, c_dat_d;
  logic                   busy, a_fire, b_fire, commit_now;

  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] w);
    logic signed [PW-1:0] sp;
    logic [PW-1:0]        up;
    logic [ACC_W-1:0]     res;
    sp = PW'($signed(a)) * PW'($signed(w));
    up = PW'(a) * PW'(w);
    if (SIGNED != 0) res = ACC_W'(sp);
    else             res = ACC_W'(up);
    return res;
  endfunction

  // A vector is in flight exactly while its valid token is somewhere in vld_q.
  assign busy       = |vld_q;
  assign a_fire     = io.io_a_valid & ~pend_q;
  assign b_fire     = io.io_b_valid & ~pend_q;
  assign commit_now = (io.io_b_commit | pend_q) & ~busy;

  assign io.io_a_ready = ~pend_q;
  assign io.io_b_ready = ~pend_q;
  assign io.io_b_count = cnt_q;
  assign io.io_c_valid = c_vld_q;
  assign io.io_c_data  = c_dat_q;
  assign io.io_busy    = busy;

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_W-1:0] sk_q [r+1];
    logic [DATA_W-1:0] sk_d [r+1];

    always_comb begin
      sk_d[0] = a_fire ? io.io_a_data[r*DATA_W +: DATA_W] : '0;
      for (int k = 1; k <= r; k++) sk_d[k] = sk_q[k-1];
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= r; k++) sk_q[k] <= '0;
      end else begin
        for (int k = 0; k <= r; k++) sk_q[k] <= sk_d[k];
      end
    end

    assign row_a[r] = sk_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign col_c[c] = ps_q[ROWS-1][c];
    end else begin : g_dly
      logic [ACC_W-1:0] dk_q [D];
      logic [ACC_W-1:0] dk_d [D];

      always_comb begin
        dk_d[0] = ps_q[ROWS-1][c];
        for (int k = 1; k < D; k++) dk_d[k] = dk_q[k-1];
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < D; k++) dk_q[k] <= '0;
        end else begin
          for (int k = 0; k < D; k++) dk_q[k] <= dk_d[k];
        end
      end

      assign col_c[c] = dk_q[D-1];
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        wsh_d[r][c]  = wsh_q[r][c];
        wact_d[r][c] = wact_q[r][c];
      end
    end

    if (b_fire) begin
      for (int c = 0; c < COLS; c++) wsh_d[0][c] = io.io_b_data[c*DATA_W +: DATA_W];
      for (int r = 1; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) wsh_d[r][c] = wsh_q[r-1][c];
      end
    end

    // Copy from wsh_d so a load on the commit edge is included.
    if (commit_now) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) wact_d[r][c] = wsh_d[r][c];
      end
    end

    for (int r = 0; r < ROWS; r++) begin
      ah_d[r][0] = row_a[r];
      for (int c = 1; c < COLS; c++) ah_d[r][c] = ah_q[r][c-1];
    end

    for (int c = 0; c < COLS; c++) ps_d[0][c] = mul_ext(ah_d[0][c], wact_q[0][c]);
    for (int r = 1; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        ps_d[r][c] = ps_q[r-1][c] + mul_ext(ah_d[r][c], wact_q[r][c]);
      end
    end

    vld_d   = {vld_q[L-2:0], a_fire};
    c_vld_d = vld_q[L-1];
    c_dat_d = vld_q[L-1] ? col_c : c_dat_q;

    cnt_d = cnt_q;
    if (commit_now) cnt_d = '0;
    else if (b_fire && cnt_q != CNT_W'(ROWS)) cnt_d = cnt_q + CNT_W'(1);

    pend_d = busy & (pend_q | io.io_b_commit);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          wsh_q[r][c]  <= '0;
          wact_q[r][c] <= '0;
          ah_q[r][c]   <= '0;
          ps_q[r][c]   <= '0;
        end
      end
      vld_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      c_vld_q <= 1'b0;
      c_dat_q <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          wsh_q[r][c]  <= wsh_d[r][c];
          wact_q[r][c] <= wact_d[r][c];
          ah_q[r][c]   <= ah_d[r][c];
          ps_q[r][c]   <= ps_d[r][c];
        end
      end
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      c_vld_q <= c_vld_d;
      c_dat_q <= c_dat_d;
    end
  end
endmodule

// File: tb/tb_ws_sta_array.sv
// Drives an unsigned and a signed 4x4 array with identical stimulus and compares both against
// a transaction-level matrix-product model with a queue of pending results.
module tb_ws_sta_array;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 18;
  localparam int L    = ROWS + COLS;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                 b_vld, b_commit, a_vld;
  logic [COLS*DW-1:0]   b_dat;
  logic [ROWS*DW-1:0]   a_dat;

  ws_sta_array_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW)) if_u ();
  ws_sta_array_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW)) if_s ();

  assign if_u.io_b_valid  = b_vld;
  assign if_u.io_b_data   = b_dat;
  assign if_u.io_b_commit = b_commit;
  assign if_u.io_a_valid  = a_vld;
  assign if_u.io_a_data   = a_dat;
  assign if_s.io_b_valid  = b_vld;
  assign if_s.io_b_data   = b_dat;
  assign if_s.io_b_commit = b_commit;
  assign if_s.io_a_valid  = a_vld;
  assign if_s.io_a_data   = a_dat;

  ws_sta_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) u_dut_u (
    .clock(clk), .reset(rst_n), .io(if_u.slave));
  ws_sta_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .SIGNED(1)) u_dut_s (
    .clock(clk), .reset(rst_n), .io(if_s.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int                 due;
    logic [COLS*AW-1:0] cu;
    logic [COLS*AW-1:0] cs;
  } res_t;

  logic [DW-1:0]      sh_m [ROWS][COLS];
  logic [DW-1:0]      ac_m [ROWS][COLS];
  int                 cnt_m;
  bit                 pend_m;
  res_t               q_m[$];
  bit                 exp_cv;
  logic [COLS*AW-1:0] exp_cu, exp_cs;
  int                 cyc, vld_seen, acc_edge, vld_edge;
  bit                 a_fired, b_fired;

  function automatic void reset_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        sh_m[r][c] = '0;
        ac_m[r][c] = '0;
      end
    cnt_m  = 0;
    pend_m = 1'b0;
    q_m.delete();
    exp_cv = 1'b0;
    exp_cu = '0;
    exp_cs = '0;
  endfunction

  function automatic void matmul(input logic [ROWS*DW-1:0] a,
                                 output logic [COLS*AW-1:0] cu, output logic [COLS*AW-1:0] cs);
    for (int c = 0; c < COLS; c++) begin
      longint su, ss;
      logic [63:0] tu, ts;
      su = 0;
      ss = 0;
      for (int r = 0; r < ROWS; r++) begin
        logic [DW-1:0] av, wv;
        av = a[r*DW +: DW];
        wv = ac_m[r][c];
        su += longint'(av) * longint'(wv);
        ss += longint'($signed(av)) * longint'($signed(wv));
      end
      tu = su;
      ts = ss;
      cu[c*AW +: AW] = tu[AW-1:0];
      cs[c*AW +: AW] = ts[AW-1:0];
    end
  endfunction

  // One clock: check the settled state, then advance the model across the rising edge.
  task automatic tick();
    bit   busy_pre, a_f, b_f, cm;
    res_t e;
    chk("a_ready", if_u.io_a_ready, !pend_m);
    chk("b_ready", if_u.io_b_ready, !pend_m);
    chk("busy", if_u.io_busy, q_m.size() > 0);
    chk("b_count", if_u.io_b_count, cnt_m);
    chk("c_valid", if_u.io_c_valid, exp_cv);
    chk("c_data_u", if_u.io_c_data, exp_cu);
    chk("c_valid_s", if_s.io_c_valid, exp_cv);
    chk("c_data_s", if_s.io_c_data, exp_cs);
    if (if_u.io_c_valid) begin
      vld_seen++;
      vld_edge = cyc;
    end
    a_f = a_vld && !pend_m;
    b_f = b_vld && !pend_m;
    @(posedge clk);
    cyc++;
    busy_pre = q_m.size() > 0;
    cm = (b_commit || pend_m) && !busy_pre;
    if (b_f) begin
      for (int r = ROWS - 1; r > 0; r--)
        for (int c = 0; c < COLS; c++) sh_m[r][c] = sh_m[r-1][c];
      for (int c = 0; c < COLS; c++) sh_m[0][c] = b_dat[c*DW +: DW];
      if (cnt_m < ROWS) cnt_m++;
    end
    if (cm) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) ac_m[r][c] = sh_m[r][c];
      cnt_m = 0;
    end
    pend_m = busy_pre && (pend_m || b_commit);
    exp_cv = 1'b0;
    if (q_m.size() > 0 && q_m[0].due == cyc) begin
      exp_cv = 1'b1;
      exp_cu = q_m[0].cu;
      exp_cs = q_m[0].cs;
      void'(q_m.pop_front());
    end
    if (a_f) begin
      e.due = cyc + L;
      matmul(a_dat, e.cu, e.cs);
      q_m.push_back(e);
      acc_edge = cyc;
    end
    a_fired = a_f;
    b_fired = b_f;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    b_vld = 0; a_vld = 0; b_commit = 0;
    repeat (n) tick();
  endtask

  task automatic drain();
    idle(0);
    for (int k = 0; k < 4 * L && q_m.size() > 0; k++) tick();
    tick();
  endtask

  task automatic push_b(input logic [COLS*DW-1:0] v);
    b_vld = 1; b_dat = v;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (b_fired) break;
    end
    b_vld = 0;
    chk("b_accept", b_fired, 1);
  endtask

  task automatic push_a(input logic [ROWS*DW-1:0] v);
    a_vld = 1; a_dat = v;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (a_fired) break;
    end
    a_vld = 0;
    chk("a_accept", a_fired, 1);
  endtask

  task automatic commit_pulse();
    b_commit = 1;
    tick();
    b_commit = 0;
  endtask

  task automatic load_mat(input logic [ROWS-1:0][COLS*DW-1:0] m);
    for (int r = ROWS - 1; r >= 0; r--) push_b(m[r]);
  endtask

  function automatic logic [ROWS-1:0][COLS*DW-1:0] diag(input logic [DW-1:0] v);
    logic [ROWS-1:0][COLS*DW-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) m[r][r*DW +: DW] = v;
    return m;
  endfunction

  function automatic logic [ROWS-1:0][COLS*DW-1:0] fill(input logic [DW-1:0] v);
    logic [ROWS-1:0][COLS*DW-1:0] m;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c*DW +: DW] = v;
    return m;
  endfunction

  function automatic logic [ROWS*DW-1:0] pack_a(input int a0, input int a1, input int a2, input int a3);
    return {a3[DW-1:0], a2[DW-1:0], a1[DW-1:0], a0[DW-1:0]};
  endfunction

  function automatic logic [COLS*AW-1:0] pack_c(input int c0, input int c1, input int c2, input int c3);
    return {c3[AW-1:0], c2[AW-1:0], c1[AW-1:0], c0[AW-1:0]};
  endfunction

  initial begin
    int base;
    b_vld = 0; b_commit = 0; a_vld = 0; b_dat = '0; a_dat = '0;
    rst_n = 0;
    cyc = 0; vld_seen = 0; acc_edge = 0; vld_edge = 0;
    reset_model();
    repeat (2) @(negedge clk);
    chk("rst_a_ready", if_u.io_a_ready, 1);
    chk("rst_b_ready", if_u.io_b_ready, 1);
    chk("rst_busy", if_u.io_busy, 0);
    chk("rst_c_valid", if_u.io_c_valid, 0);
    chk("rst_c_data", if_u.io_c_data, 0);
    chk("rst_count", if_u.io_b_count, 0);
    rst_n = 1;

    // Identity weights, latency and count
    load_mat(diag(8'd1));
    chk("t1_cnt_pre", if_u.io_b_count, 4);
    commit_pulse();
    chk("t1_cnt_post", if_u.io_b_count, 0);
    push_a(pack_a(1, 2, 3, 4));
    drain();
    chk("t1_latency", vld_edge - acc_edge, 8);
    chk("t1_c", if_u.io_c_data, pack_c(1, 2, 3, 4));

    // Unsigned worst case
    load_mat(fill(8'hFF));
    commit_pulse();
    push_a(pack_a(255, 255, 255, 255));
    drain();
    chk("t2_c_u", if_u.io_c_data, pack_c(260100, 260100, 260100, 260100));
    chk("t2_c_s", if_s.io_c_data, pack_c(4, 4, 4, 4));

    // Signed negative identity
    load_mat(diag(8'hFF));
    commit_pulse();
    push_a(pack_a(1, -2, 3, -4));
    drain();
    chk("t3_c_s", if_s.io_c_data, pack_c(-1, 2, -3, 4));
    chk("t3_c_u", if_u.io_c_data, pack_c(255, 64770, 765, 64260));

    // Back-to-back stream
    load_mat(diag(8'd1));
    commit_pulse();
    base = vld_seen;
    a_vld = 1;
    for (int i = 0; i < 4; i++) begin
      a_dat = pack_a(4*i + 1, 4*i + 2, 4*i + 3, 4*i + 4);
      tick();
    end
    a_vld = 0;
    drain();
    chk("t4_pulses", vld_seen - base, 4);
    chk("t4_last", if_u.io_c_data, pack_c(13, 14, 15, 16));
    chk("t4_busy_end", if_u.io_busy, 0);

    // Commit while busy stalls both streams until the pipeline drains
    load_mat(diag(8'd2));
    push_a(pack_a(3, 5, 7, 9));
    idle(1);
    commit_pulse();
    chk("t5_a_stall", if_u.io_a_ready, 0);
    chk("t5_b_stall", if_u.io_b_ready, 0);
    for (int k = 0; k < 4 * L && !if_u.io_c_valid; k++) tick();
    chk("t5_inflight", if_u.io_c_data, pack_c(3, 5, 7, 9));
    push_a(pack_a(10, 20, 30, 40));
    drain();
    chk("t5_new_w", if_u.io_c_data, pack_c(20, 40, 60, 80));

    // Reset mid-flight discards everything
    push_a(pack_a(1, 1, 1, 1));
    idle(3);
    #2 rst_n = 0;
    #1;
    chk("t6_c_valid", if_u.io_c_valid, 0);
    chk("t6_c_data", if_u.io_c_data, 0);
    chk("t6_busy", if_u.io_busy, 0);
    chk("t6_a_ready", if_u.io_a_ready, 1);
    chk("t6_count", if_u.io_b_count, 0);
    reset_model();
    base = vld_seen;
    @(negedge clk);
    rst_n = 1;
    idle(L + 4);
    chk("t6_no_pulse", vld_seen - base, 0);

    // Randomised traffic: partial loads, stray commits, gapped A stream
    for (int i = 0; i < 400; i++) begin
      b_vld    = ($urandom_range(0, 2) == 0);
      b_dat    = $urandom;
      a_vld    = ($urandom_range(0, 1) == 0);
      a_dat    = $urandom;
      b_commit = ($urandom_range(0, 11) == 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
